// File: rtl/y_deser_pkg.sv
// rtl/y_deser_pkg.sv - shared types and helpers for the y_deserializer
// Holds the default word width, the output-register state enum and the
// bit counter width function.
package y_deser_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } out_state_e;

  // Bit counter width; at least one bit so WIDTH=2 still has a counter.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/y_deserializer.sv
// rtl/y_deserializer.sv - serial-to-parallel word assembler with hold/overflow
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   y_in, y_valid       serial bit and its qualifier
//   flush               discard the partial word
//   clr_ovf             clear the sticky overflow flag
//   out_ready           downstream takes the held word
//   word_data           assembled word
//   word_parity         XOR of word_data
//   word_valid          word_data/word_parity valid (HOLD state)
//   overflow            sticky: a completed word was dropped
//   bit_cnt             bits accepted into the current partial word
module y_deserializer
  import y_deser_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          y_in,
  input  logic                          y_valid,
  input  logic                          flush,
  input  logic                          clr_ovf,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              word_data,
  output logic                          word_parity,
  output logic                          word_valid,
  output logic                          overflow,
  output logic [cnt_width(WIDTH)-1:0]   bit_cnt
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Only WIDTH-1 bits of a partial word ever need storing; the WIDTH-th
  // bit is taken straight from y_in when the word completes.
  logic [WIDTH-2:0] shift_q;
  logic [WIDTH-2:0] shift_d;
  logic [WIDTH-1:0] next_word;
  logic             accept;
  logic             complete;
  out_state_e       state;

  always_comb begin
    accept    = y_valid & ~flush;
    complete  = accept && (bit_cnt == LAST);
    next_word = '0;
    shift_d   = '0;
    if (MSB_FIRST) begin
      // Shift left: earliest bit migrates toward the MSB.
      next_word = {shift_q, y_in};
      shift_d   = next_word[WIDTH-2:0];
    end else begin
      // Shift right: earliest bit migrates toward bit 0.
      next_word = {y_in, shift_q};
      shift_d   = next_word[WIDTH-1:1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      bit_cnt     <= '0;
      word_data   <= '0;
      word_parity <= 1'b0;
      word_valid  <= 1'b0;
      overflow    <= 1'b0;
      state       <= EMPTY;
    end else begin
      if (flush) begin
        shift_q <= '0;
        bit_cnt <= '0;
      end else if (accept) begin
        shift_q <= shift_d;
        bit_cnt <= complete ? '0 : bit_cnt + CW'(1);
      end

      // Clear first so a drop on the same edge leaves the flag set.
      if (clr_ovf) overflow <= 1'b0;

      case (state)
        EMPTY: begin
          if (complete) begin
            word_data   <= next_word;
            word_parity <= ^next_word;
            word_valid  <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (complete) begin
            if (out_ready) begin
              word_data   <= next_word;
              word_parity <= ^next_word;
            end else begin
              overflow <= 1'b1;
            end
          end else if (out_ready) begin
            word_valid <= 1'b0;
            state      <= EMPTY;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y_deserializer.sv
// tb/tb_y_deserializer.sv - randomized and directed bench for y_deserializer
module tb_y_deserializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic y_in = 1'b0, y_valid = 1'b0, flush = 1'b0, clr_ovf = 1'b0, out_ready = 1'b0;

  logic [7:0] m_data, l_data;
  logic       m_par, l_par, m_vld, l_vld, m_ovf, l_ovf;
  logic [2:0] m_cnt, l_cnt;

  y_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .y_in(y_in), .y_valid(y_valid), .flush(flush),
    .clr_ovf(clr_ovf), .out_ready(out_ready), .word_data(m_data),
    .word_parity(m_par), .word_valid(m_vld), .overflow(m_ovf), .bit_cnt(m_cnt)
  );

  y_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .y_in(y_in), .y_valid(y_valid), .flush(flush),
    .clr_ovf(clr_ovf), .out_ready(out_ready), .word_data(l_data),
    .word_parity(l_par), .word_valid(l_vld), .overflow(l_ovf), .bit_cnt(l_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the partial word is a list of bits in arrival order.
  bit         bits_q[$];
  bit         ref_vld;
  bit         ref_ovf;
  logic [7:0] ref_msb, ref_lsb;

  function automatic logic [7:0] pack(input bit msb);
    logic [7:0] r = '0;
    foreach (bits_q[i]) begin
      if (msb) r[7-i] = bits_q[i];
      else     r[i]   = bits_q[i];
    end
    return r;
  endfunction

  function automatic logic parity_of(input logic [7:0] w);
    return logic'($countones(w) % 2);
  endfunction

  task automatic model_reset();
    bits_q.delete();
    ref_vld = 0; ref_ovf = 0; ref_msb = '0; ref_lsb = '0;
  endtask

  task automatic model_edge(input bit yv, input bit yi, input bit fl,
                            input bit co, input bit rdy);
    bit         done = 0;
    logic [7:0] wm = '0, wl = '0;
    if (fl) bits_q.delete();
    else if (yv) begin
      bits_q.push_back(yi);
      if (bits_q.size() == 8) begin
        done = 1; wm = pack(1); wl = pack(0);
        bits_q.delete();
      end
    end
    if (co) ref_ovf = 0;
    if (!ref_vld) begin
      if (done) begin ref_vld = 1; ref_msb = wm; ref_lsb = wl; end
    end else if (done) begin
      if (rdy) begin ref_msb = wm; ref_lsb = wl; end
      else ref_ovf = 1;
    end else if (rdy) ref_vld = 0;
  endtask

  task automatic compare_all();
    check_eq("msb_valid",  m_vld,  ref_vld);
    check_eq("msb_data",   m_data, ref_msb);
    check_eq("msb_parity", m_par,  parity_of(ref_msb));
    check_eq("msb_ovf",    m_ovf,  ref_ovf);
    check_eq("msb_cnt",    m_cnt,  bits_q.size());
    check_eq("lsb_valid",  l_vld,  ref_vld);
    check_eq("lsb_data",   l_data, ref_lsb);
    check_eq("lsb_parity", l_par,  parity_of(ref_lsb));
    check_eq("lsb_ovf",    l_ovf,  ref_ovf);
    check_eq("lsb_cnt",    l_cnt,  bits_q.size());
  endtask

  // One clock: drive, let the edge happen, advance the model, check.
  task automatic step(input bit yv, input bit yi, input bit fl,
                      input bit co, input bit rdy);
    y_valid = yv; y_in = yi; flush = fl; clr_ovf = co; out_ready = rdy;
    @(posedge clk);
    model_edge(yv, yi, fl, co, rdy);
    #1;
    compare_all();
  endtask

  task automatic send_byte(input logic [7:0] v, input bit rdy);
    for (int i = 7; i >= 0; i--) step(1, v[i], 0, 0, rdy);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_data",  {m_data, l_data}, 16'h0);
    check_eq("rst_flags", {m_vld, m_par, m_ovf, l_vld, l_par, l_ovf}, 6'h0);
    check_eq("rst_cnt",   {m_cnt, l_cnt}, 6'h0);
    #1 rst_n = 1'b1;
  endtask

  int pulses;
  int last_pulse;
  int gap_bad;

  initial begin
    model_reset();
    #12;
    check_eq("reset_valid", {m_vld, l_vld}, 2'b00);
    check_eq("reset_cnt",   {m_cnt, l_cnt}, 6'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    compare_all();

    // Serial 1,0,1,1,0,0,1,0 with out_ready high
    send_byte(8'hB2, 1);
    check_eq("b2_msb_data", m_data, 8'hB2);
    check_eq("4d_lsb_data", l_data, 8'h4D);
    check_eq("b2_parity",   {m_par, l_par}, 2'b00);
    check_eq("b2_valid",    m_vld, 1'b1);
    step(0, 0, 0, 0, 1);
    check_eq("b2_valid_one_cycle", m_vld, 1'b0);

    // Hold with out_ready low: second word dropped
    send_byte(8'hFF, 0);
    send_byte(8'h00, 0);
    check_eq("drop_data", m_data, 8'hFF);
    check_eq("drop_ovf",  m_ovf, 1'b1);
    step(0, 0, 0, 1, 0);
    check_eq("clr_ovf",       m_ovf, 1'b0);
    check_eq("clr_keep_data", m_data, 8'hFF);
    step(0, 0, 0, 0, 1);

    // Partial word, flush together with a valid bit, then a fresh word
    step(1, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    step(1, 1, 1, 0, 1);
    check_eq("flush_cnt", m_cnt, 3'd0);
    send_byte(8'hA5, 1);
    check_eq("flush_a5", m_data, 8'hA5);
    step(0, 0, 0, 0, 1);

    // Reset in the middle of a word
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 1);
    async_reset();
    send_byte(8'h3C, 1);
    check_eq("post_rst_3c", m_data, 8'h3C);
    step(0, 0, 0, 0, 1);

    // Back-to-back words with out_ready held high
    pulses = 0; last_pulse = -1; gap_bad = 0;
    for (int c = 0; c < 32; c++) begin
      step(1, 1'($urandom), 0, 0, 1);
      if (m_vld) begin
        if (last_pulse >= 0 && c - last_pulse != 8) gap_bad++;
        last_pulse = c;
        pulses++;
      end
    end
    check_eq("b2b_pulses", pulses, 4);
    check_eq("b2b_gaps",   gap_bad, 0);
    check_eq("b2b_no_ovf", m_ovf, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(0, 9) < 8), 1'($urandom), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0));
      if (c == 300) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/y_deserializer.md
Y_DESERIALIZER -- requirements
Module: y_deserializer

Interface
REQ-001 Parameter: WIDTH, 8, bits per assembled word; legal range 2..16.
REQ-002 Parameter: MSB_FIRST, 1, 1 = first accepted bit lands in word_data[WIDTH-1]; 0 = first bit lands in word_data[0].
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port: y_in  input  1  serial result bit from the upstream mux stage.
REQ-006 Port: y_valid  input  1  y_in is valid this cycle.
REQ-007 Port: flush  input  1  synchronous discard of the partial word.
REQ-008 Port: clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-009 Port: out_ready  input  1  downstream accepts word_data this cycle.
REQ-010 Port: word_data  output  WIDTH  assembled word.
REQ-011 Port: word_parity  output  1  XOR of all bits of word_data.
REQ-012 Port: word_valid  output  1  word_data and word_parity are valid.
REQ-013 Port: overflow  output  1  sticky; a completed word was dropped.
REQ-014 Port: bit_cnt  output  clog2(WIDTH)  bits accepted into the current partial word.

Function
REQ-015 A bit SHALL be accepted on every rising clk edge where y_valid=1 and flush=0; bit_cnt SHALL increment by 1.
REQ-016 When the accepted bit is the WIDTH-th bit (bit_cnt==WIDTH-1), the word SHALL be complete and bit_cnt SHALL wrap to 0 on the same edge.
REQ-017 Output register states: EMPTY (word_valid=0) and HOLD (word_valid=1).
REQ-018 Transition EMPTY->HOLD: a word completes; word_valid SHALL rise on the edge that accepts the WIDTH-th bit, giving 0-cycle latency from that edge and 1 cycle from the bit's presentation.
REQ-019 Transition HOLD->EMPTY: out_ready=1 and no word completes on the same edge.
REQ-020 HOLD with out_ready=1 and a word completing on the same edge: the new word SHALL load and state SHALL remain HOLD (back-to-back, no bubble).
REQ-021 HOLD with out_ready=0 and a word completing: the new word SHALL be dropped, overflow SHALL be set, word_data SHALL keep its old value, and bit_cnt SHALL still wrap to 0.
REQ-022 In HOLD, word_data and word_parity SHALL remain stable until out_ready=1.
REQ-023 word_parity SHALL be computed from the word as loaded and registered with word_data.
REQ-024 flush=1 SHALL set bit_cnt to 0 and discard the partial shift contents; it SHALL NOT affect word_valid, word_data, or overflow.
REQ-025 If flush=1 and y_valid=1 on the same edge, flush SHALL win and the bit SHALL be discarded.
REQ-026 If clr_ovf=1 and a drop event occur on the same edge, overflow SHALL be 1 (set wins).
REQ-027 out_ready while EMPTY SHALL be ignored.

Reset
REQ-028 rst_n=0 SHALL immediately force bit_cnt=0, word_valid=0, word_data=0, word_parity=0, overflow=0, shift register=0, and state=EMPTY, regardless of clk.
REQ-029 A partial word in progress when reset asserts SHALL be lost; after reset deassertion, the first accepted bit SHALL be bit 0 of a new word.

Structure
REQ-030 Package y_deser_pkg SHALL hold the WIDTH default, the output-state enum (EMPTY, HOLD), and the clog2-based counter width function.
REQ-031 The block SHALL be a single flat module with no sub-module: a shift register, counter, and two-state output register.

Verification
REQ-032 WIDTH=8, MSB_FIRST=1: serial 1,0,1,1,0,0,1,0 with y_valid=1 and out_ready=1 -> word_data=8'hB2, word_parity=0, word_valid high for 1 cycle.
REQ-033 MSB_FIRST=0: same bits -> word_data=8'h4D, word_parity=0.
REQ-034 out_ready=0, two full words streamed (0xFF then 0x00) -> word_data stays 0xFF, overflow=1; pulse clr_ovf -> overflow=0, word_data still 0xFF.
REQ-035 3 bits accepted, then flush=1 together with y_valid=1, then 8 bits of 0xA5 -> word_data=0xA5, bit_cnt=0 after the flush edge.
REQ-036 5 bits accepted, then rst_n pulsed low mid-cycle -> all outputs 0 asynchronously; next 8 bits of 0x3C -> word_data=0x3C.
REQ-037 Continuous y_valid=1 with out_ready=1 for 4 words -> word_valid pulses every 8 cycles, with no drops and no overflow.
